demux_stream_dispatch: RTL and testbench

- Registered 1-to-NUM_OUT stream dispatcher with valid/ready handshakes; routes each input word to exactly one output lane.
- Lane choice is either the explicit in_dest field (addressed mode) or an internal round-robin pointer (rr mode).
- Sits directly upstream of the 1xN demux fabric. It generates the registered select and one-hot lane strobes that the fabric consumes, and adds backpressure and illegal-destination handling.

---
 rtl/demux_dispatch_pkg.sv | 24 ++
 rtl/demux_stream_dispatch_mod_n_counter.sv | 25 ++
 rtl/demux_stream_dispatch.sv | 120 ++++++++++++
 tb/tb_demux_stream_dispatch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_dispatch_pkg.sv
// Shared types and helpers for the stream dispatcher.
//   state_t  : dispatcher FSM encoding (EMPTY holds nothing, FULL holds one word)
//   MODE_*   : in_mode encodings
//   onehot() : MAX_OUT-wide one-hot of idx, all-zero when idx >= n
package demux_dispatch_pkg;

  localparam int MAX_OUT = 64;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic [MAX_OUT-1:0] onehot(input int idx, input int n);
    logic [MAX_OUT-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < MAX_OUT) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_stream_dispatch_mod_n_counter.sv
// Modulo-N up counter used as the round-robin lane pointer.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   en         : advance by one this cycle, wrapping N-1 -> 0
//   count      : current value, 0..N-1
module mod_n_counter #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/demux_stream_dispatch.sv
// Registered 1-to-NUM_OUT stream dispatcher feeding a 1xN demux fabric.
// Each accepted word is routed to exactly one lane, chosen by in_dest
// (addressed mode) or by an internal round-robin pointer (rr mode).
// Words addressed to a lane >= NUM_OUT are dropped and counted.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : input payload
//   in_dest    : destination lane (addressed mode only)
//   in_mode    : 0 = addressed, 1 = round-robin, sampled per accepted word
//   in_valid   : upstream word valid
//   in_ready   : dispatcher can accept this cycle
//   out_data   : registered payload, shared by all lanes
//   out_sel    : registered binary index of the held word's lane
//   out_valid  : one-hot lane valid, all-zero when empty
//   out_ready  : per-lane ready
//   rr_ptr     : next round-robin lane
//   err_cnt    : saturating count of dropped illegal-destination words
//
// Handshake: a word moves when valid and ready are both high on a rising
// edge. Upstream accept = in_valid & in_ready; lane transfer =
// |(out_valid & out_ready). Once raised, out_valid/out_data/out_sel stay
// stable until the transfer. The only combinational path is
// out_ready -> in_ready.
module demux_stream_dispatch
  import demux_dispatch_pkg::*;
#(
  parameter int NUM_OUT = 8,
  parameter int NUM_SEL = $clog2(NUM_OUT),
  parameter int DATA_W  = 8,
  parameter int ERR_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [NUM_SEL-1:0] in_dest,
  input  logic               in_mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [NUM_SEL-1:0] out_sel,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [NUM_SEL-1:0] rr_ptr,
  output logic [ERR_W-1:0]   err_cnt
);

  // One extra bit so NUM_OUT itself is representable for the legality test.
  localparam logic [NUM_SEL:0] NUM_OUT_L = NUM_OUT[NUM_SEL:0];

  state_t             state;
  logic [NUM_SEL-1:0] dest;
  logic               legal;
  logic               accept;
  logic               transfer;
  logic [MAX_OUT-1:0] dest_oh;

  assign dest     = (in_mode == MODE_RR) ? rr_ptr : in_dest;
  assign legal    = ({1'b0, dest} < NUM_OUT_L);
  assign dest_oh  = onehot(int'(dest), NUM_OUT);
  assign transfer = |(out_valid & out_ready);

  // While FULL, a new word can only enter on the edge the held word leaves.
  assign in_ready = rst_n & ((state == EMPTY) | out_ready[out_sel]);
  assign accept   = in_valid & in_ready;

  mod_n_counter #(
    .N (NUM_OUT),
    .W (NUM_SEL)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept & (in_mode == MODE_RR)),
    .count (rr_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= '0;
      err_cnt   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            if (legal) begin
              out_data  <= in_data;
              out_sel   <= dest;
              out_valid <= dest_oh[NUM_OUT-1:0];
              state     <= FULL;
            end else if (err_cnt != '1) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (transfer) begin
            if (accept && legal) begin
              // Refill on the same edge for one word per cycle.
              out_data  <= in_data;
              out_sel   <= dest;
              out_valid <= dest_oh[NUM_OUT-1:0];
            end else begin
              out_valid <= '0;
              state     <= EMPTY;
              if (accept && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_stream_dispatch.sv
// Directed bench for demux_stream_dispatch: an 8-lane instance for
// addressed, round-robin, backpressure and reset cases, and a 6-lane
// instance for illegal-destination dropping and counter saturation.
module tb_demux_stream_dispatch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 8-lane instance ----------------
  logic [7:0] a_in_data;
  logic [2:0] a_in_dest;
  logic       a_in_mode;
  logic       a_in_valid;
  logic       a_in_ready;
  logic [7:0] a_out_data;
  logic [2:0] a_out_sel;
  logic [7:0] a_out_valid;
  logic [7:0] a_out_ready;
  logic [2:0] a_rr_ptr;
  logic [7:0] a_err_cnt;

  demux_stream_dispatch #(.NUM_OUT(8), .DATA_W(8), .ERR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_dest(a_in_dest), .in_mode(a_in_mode),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_sel(a_out_sel), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .rr_ptr(a_rr_ptr), .err_cnt(a_err_cnt)
  );

  // ---------------- 6-lane instance ----------------
  logic [7:0] b_in_data;
  logic [2:0] b_in_dest;
  logic       b_in_mode;
  logic       b_in_valid;
  logic       b_in_ready;
  logic [7:0] b_out_data;
  logic [2:0] b_out_sel;
  logic [5:0] b_out_valid;
  logic [5:0] b_out_ready;
  logic [2:0] b_rr_ptr;
  logic [7:0] b_err_cnt;

  demux_stream_dispatch #(.NUM_OUT(6), .DATA_W(8), .ERR_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_dest(b_in_dest), .in_mode(b_in_mode),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .rr_ptr(b_rr_ptr), .err_cnt(b_err_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver helpers ----------------
  // Inputs change at the falling edge; outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic m, input logic [2:0] d, input logic [7:0] x);
    @(negedge clk);
    a_in_valid = v;
    a_in_mode  = m;
    a_in_dest  = d;
    a_in_data  = x;
  endtask

  task automatic drive_b(input logic v, input logic [2:0] d, input logic [7:0] x);
    @(negedge clk);
    b_in_valid = v;
    b_in_mode  = 1'b0;
    b_in_dest  = d;
    b_in_data  = x;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a_in_data = '0; a_in_dest = '0; a_in_mode = 1'b0; a_in_valid = 1'b0;
    a_out_ready = 8'hFF;
    b_in_data = '0; b_in_dest = '0; b_in_mode = 1'b0; b_in_valid = 1'b0;
    b_out_ready = 6'h3F;

    // Reset state.
    repeat (3) step();
    check("rst_in_ready", a_in_ready, 1'b0);
    check("rst_out_valid", a_out_valid, 8'h00);
    check("rst_out_data", a_out_data, 8'h00);
    check("rst_out_sel", a_out_sel, 3'd0);
    check("rst_rr_ptr", a_rr_ptr, 3'd0);
    check("rst_err_cnt", a_err_cnt, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Addressed delivery: 0xA0..0xA7 to lanes 7..0, back to back.
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, 1'b0, 3'(7 - i), 8'(8'hA0 + i));
      #1 check("addr_in_ready", a_in_ready, 1'b1);
      step();
      check("addr_out_valid", a_out_valid, 64'(8'h80 >> i));
      check("addr_out_sel", a_out_sel, 64'(7 - i));
      check("addr_out_data", a_out_data, 64'(8'hA0 + i));
    end
    drive_a(1'b0, 1'b0, 3'd0, 8'h00);
    step();
    check("addr_drain", a_out_valid, 8'h00);
    check("addr_rr_ptr", a_rr_ptr, 3'd0);

    // Round-robin: 10 words, lanes 0..7,0,1 at one word per cycle.
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, 1'b1, 3'd7, 8'(8'h10 + i));
      #1 check("rr_in_ready", a_in_ready, 1'b1);
      step();
      check("rr_out_sel", a_out_sel, 64'(i % 8));
      check("rr_out_valid", a_out_valid, 64'(8'h01 << (i % 8)));
      check("rr_out_data", a_out_data, 64'(8'h10 + i));
    end
    drive_a(1'b0, 1'b0, 3'd0, 8'h00);
    step();
    check("rr_ptr_end", a_rr_ptr, 3'd2);
    check("rr_drain", a_out_valid, 8'h00);

    // Backpressure on lane 3 with a pending second word.
    a_out_ready = 8'hF7;
    drive_a(1'b1, 1'b0, 3'd3, 8'h55);
    step();
    check("bp_load_valid", a_out_valid, 8'h08);
    drive_a(1'b1, 1'b0, 3'd3, 8'h66);
    for (int i = 0; i < 4; i++) begin
      #1 check("bp_in_ready", a_in_ready, 1'b0);
      step();
      check("bp_hold_valid", a_out_valid, 8'h08);
      check("bp_hold_data", a_out_data, 8'h55);
      @(negedge clk);
    end
    a_out_ready = 8'hFF;
    #1 check("bp_release_ready", a_in_ready, 1'b1);
    step();
    check("bp_reload_data", a_out_data, 8'h66);
    check("bp_reload_valid", a_out_valid, 8'h08);
    drive_a(1'b0, 1'b0, 3'd0, 8'h00);
    step();
    check("bp_drain", a_out_valid, 8'h00);

    // Ready on every lane except the held one: no transfer.
    a_out_ready = 8'hFB;
    drive_a(1'b1, 1'b0, 3'd2, 8'h22);
    step();
    drive_a(1'b0, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      #1 check("wl_in_ready", a_in_ready, 1'b0);
      step();
      check("wl_hold_valid", a_out_valid, 8'h04);
      check("wl_hold_data", a_out_data, 8'h22);
      @(negedge clk);
    end
    a_out_ready = 8'hFF;
    step();
    check("wl_drain", a_out_valid, 8'h00);

    // Illegal destinations on the 6-lane instance.
    drive_b(1'b1, 3'd6, 8'h01);
    step();
    check("ill6_valid", b_out_valid, 6'h00);
    check("ill6_err", b_err_cnt, 8'd1);
    drive_b(1'b1, 3'd7, 8'h02);
    step();
    check("ill7_valid", b_out_valid, 6'h00);
    check("ill7_err", b_err_cnt, 8'd2);
    drive_b(1'b1, 3'd5, 8'h03);
    step();
    check("leg5_valid", b_out_valid, 6'h20);
    check("leg5_sel", b_out_sel, 3'd5);
    check("leg5_err", b_err_cnt, 8'd2);
    // 300 illegal words: the first drains the held word, all are counted.
    for (int i = 0; i < 300; i++) begin
      drive_b(1'b1, 3'd7, 8'(i));
      step();
      if (i == 0) begin
        check("ill_full_drop_valid", b_out_valid, 6'h00);
        check("ill_full_drop_err", b_err_cnt, 8'd3);
      end
    end
    drive_b(1'b0, 3'd0, 8'h00);
    step();
    check("sat_err", b_err_cnt, 8'hFF);
    check("sat_valid", b_out_valid, 6'h00);
    check("sat_rr_ptr", b_rr_ptr, 3'd0);

    // Reset mid-FULL: lane 4 held with rr_ptr=5.
    drive_a(1'b1, 1'b1, 3'd0, 8'h32);
    step();
    check("pre_rst_sel2", a_out_sel, 3'd2);
    drive_a(1'b1, 1'b1, 3'd0, 8'h33);
    step();
    drive_a(1'b0, 1'b0, 3'd0, 8'h00);
    step();
    a_out_ready = 8'h00;
    drive_a(1'b1, 1'b1, 3'd0, 8'h44);
    step();
    drive_a(1'b0, 1'b0, 3'd0, 8'h00);
    step();
    check("pre_rst_valid", a_out_valid, 8'h10);
    check("pre_rst_rr_ptr", a_rr_ptr, 3'd5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", a_out_valid, 8'h00);
    check("arst_rr_ptr", a_rr_ptr, 3'd0);
    check("arst_err_a", a_err_cnt, 8'h00);
    check("arst_err_b", b_err_cnt, 8'h00);
    check("arst_in_ready", a_in_ready, 1'b0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 8'hFF;
    drive_a(1'b1, 1'b1, 3'd6, 8'h77);
    step();
    check("post_rst_sel", a_out_sel, 3'd0);
    check("post_rst_valid", a_out_valid, 8'h01);
    check("post_rst_data", a_out_data, 8'h77);
    check("post_rst_rr_ptr", a_rr_ptr, 3'd1);
    drive_a(1'b0, 1'b0, 3'd0, 8'h00);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
